// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO sequential divide unit: op codes, read selects
// and the FSM state type.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_DIVU = 3'b001,
    OP_DIV  = 3'b010,
    OP_MTHI = 3'b011,
    OP_MTLO = 3'b100
  } opCode_t;

  typedef enum logic [1:0] {
    MF_NONE  = 2'b00,
    MF_NONE1 = 2'b01,
    MF_HI    = 2'b10,
    MF_LO    = 2'b11
  } mfCode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// EX-stage bundle between the pipeline and the HI/LO unit; the pipeline is the
// master, the HI/LO unit the slave.
interface hilo_muldiv_seq_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [2:0]       opE;
  logic [1:0]       mfE;
  logic [WIDTH-1:0] Out;
  logic             busyE;
  logic             stallE;

  modport master (output SrcAE, SrcBE, opE, mfE, input Out, busyE, stallE);
  modport slave  (input SrcAE, SrcBE, opE, mfE, output Out, busyE, stallE);

endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider, one quotient bit per step. start loads operands;
// done flags the edge on which the final step is taken.
module div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   remShift;
  logic [WIDTH+1:0] trial;
  logic             unusedTrialBit;

  // A non-negative trial difference is always below the divisor, so only the
  // low WIDTH bits are ever kept.
  assign remShift       = {remReg, quoReg[WIDTH-1]};
  assign trial          = {1'b0, remShift} - {2'b00, divReg};
  assign unusedTrialBit = trial[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remReg <= '0;
      quoReg <= '0;
      divReg <= '0;
      count  <= '0;
    end else if (start) begin
      remReg <= '0;
      quoReg <= dividend;
      divReg <= divisor;
      count  <= '0;
    end else if (step) begin
      if (!trial[WIDTH+1]) begin
        remReg <= trial[WIDTH-1:0];
        quoReg <= {quoReg[WIDTH-2:0], 1'b1};
      end else begin
        remReg <= remShift[WIDTH-1:0];
        quoReg <= {quoReg[WIDTH-2:0], 1'b0};
      end
      count <= count + CNT_W'(1);
    end
  end

  assign done      = step && (count == CNT_W'(WIDTH - 1));
  assign quotient  = quoReg;
  assign remainder = remReg;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Architectural HI/LO registers with an iterative DIV/DIVU, MTHI/MTLO writes,
// MFHI/MFLO read mux and the stall request raised while a divide is in flight.
module hilo_muldiv_seq
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_seq_if.slave  bus
);

  state_t           state;
  state_t           nextState;
  logic             startDiv;
  logic             writeDiv;
  logic             doneDiv;
  logic             isDivOp;
  logic             isSigned;
  logic             negQuo;
  logic             negRem;
  logic             busy;
  logic [WIDTH:0]   extA;
  logic [WIDTH:0]   extB;
  logic [WIDTH:0]   magA;
  logic [WIDTH:0]   magB;
  logic [1:0]       unusedMagBits;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  assign isDivOp  = (bus.opE == OP_DIVU) || (bus.opE == OP_DIV);
  assign isSigned = (bus.opE == OP_DIV);

  // One extra bit keeps the magnitude of the most negative operand exact.
  assign extA          = {isSigned & bus.SrcAE[WIDTH-1], bus.SrcAE};
  assign extB          = {isSigned & bus.SrcBE[WIDTH-1], bus.SrcBE};
  assign magA          = extA[WIDTH] ? -extA : extA;
  assign magB          = extB[WIDTH] ? -extB : extB;
  assign unusedMagBits = {magA[WIDTH], magB[WIDTH]};

  div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) core (
    .clk       (clk),
    .reset     (reset),
    .start     (startDiv),
    .step      (state == ST_RUN),
    .dividend  (magA[WIDTH-1:0]),
    .divisor   (magB[WIDTH-1:0]),
    .done      (doneDiv),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      negQuo <= 1'b0;
      negRem <= 1'b0;
    end else begin
      state <= nextState;
      if (startDiv) begin
        negQuo <= extA[WIDTH] ^ extB[WIDTH];
        negRem <= extA[WIDTH];
      end
    end
  end

  // New ops are only accepted in IDLE; while busy the pipeline re-presents them.
  always_comb begin
    nextState = state;
    startDiv  = 1'b0;
    writeDiv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (isDivOp) begin
          startDiv  = 1'b1;
          nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (doneDiv) nextState = ST_DONE;
      end
      ST_DONE: begin
        writeDiv  = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (writeDiv) begin
      hiReg <= negRem ? -remainder : remainder;
      loReg <= negQuo ? -quotient : quotient;
    end else if (state == ST_IDLE) begin
      if (bus.opE == OP_MTHI) hiReg <= bus.SrcAE;
      if (bus.opE == OP_MTLO) loReg <= bus.SrcAE;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign bus.busyE  = busy;
  assign bus.stallE = busy & (bus.mfE[1] | (bus.opE != OP_NONE));
  assign bus.Out    = (bus.mfE == MF_HI) ? hiReg :
                      (bus.mfE == MF_LO) ? loReg : '0;

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Sequential HI/LO producer for the EX stage: an iterative 1-bit-per-cycle restoring divider plus MTHI/MTLO direct writes.
- Owns the architectural HI/LO registers and serves MFHI/MFLO reads from them.
- Drives a stall request to the hazard unit while a divide is in flight, so dependent HI/LO traffic waits for the result.
- Replaces the single-cycle combinational divide path.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk      input   1      rising-edge clock
- reset    input   1      asynchronous, active-high reset
- SrcAE    input   WIDTH  dividend / MTHI-MTLO source
- SrcBE    input   WIDTH  divisor
- opE      input   3      000 none, 001 DIVU, 010 DIV (signed), 011 MTHI, 100 MTLO; others treated as none
- mfE      input   2      00 none, 01 none, 10 MFHI, 11 MFLO
- Out      output  WIDTH  HI/LO read data
- busyE    output  1      divide in flight
- stallE   output  1      stall request to hazard unit

Behaviour:
- Reset (async, any time, including mid-divide):
  - HI=0, LO=0, busyE=0, stallE=0, Out=0.
  - FSM goes to IDLE; counter and working registers are cleared.
  - An in-flight divide is discarded; HI/LO are not written.
- FSM states IDLE, RUN, DONE:
  - IDLE: opE=DIVU/DIV at edge E0 captures operands (|A|, |B| and sign flags for DIV; raw for DIVU) and goes to RUN with count=0.
  - IDLE: opE=MTHI/MTLO at an edge writes SrcAE into HI/LO at that edge; stays IDLE.
  - RUN: one restoring step per edge (shift remainder:quotient left 1, trial-subtract divisor, keep if non-negative, set quotient bit). count increments; after the step with count=WIDTH-1, goes to DONE. WIDTH edges total, E1..E32.
  - DONE (edge E33): applies sign fixup, writes HI=remainder and LO=quotient, returns to IDLE.
- busyE: 1 in RUN and DONE (after E0 through E33), else 0.
  - Divide latency: start edge plus 33 edges.
  - An MFHI/MFLO issued in the cycle after E33 sees the new value.
- stallE (combinational): busyE & ((mfE[1]==1) | (opE!=000)).
  - While busy, new ops are ignored; the pipeline holds them and re-presents them.
- Out (combinational):
  - mfE=10 gives HI; mfE=11 gives LO; otherwise 0.
  - Reads registered HI/LO only. There is no bypass of a same-edge MTHI/MTLO write.
- Signed rules (DIV):
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - Magnitudes are computed in WIDTH+1 bits so -2^31 is handled.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (wraps; no trap).
- Divide by zero (result comes out of the restoring algorithm, not flagged):
  - DIVU: LO=all ones, HI=dividend.
  - DIV: magnitudes as for DIVU, then the sign fixup is applied.
  - No exception, latency unchanged.
- Simultaneous events: opE and mfE together in IDLE are legal. Out shows the old HI/LO; the write lands at the edge.

Decomposition:
- Shared package (hilo_pkg) holds:
  - op codes OP_NONE/OP_DIVU/OP_DIV/OP_MTHI/OP_MTLO
  - mf codes MF_HI/MF_LO
  - FSM state encoding ST_IDLE/ST_RUN/ST_DONE
- One natural sub-module, div_core:
  - unsigned iterative restoring datapath (remainder/quotient shift registers, subtractor, counter)
  - start/done handshake
- The top holds the FSM glue, sign handling, HI/LO registers, the read mux and the stall logic.

Test Plan:
- DIVU A=100, B=7 at E0; mfE=11 after E33 -> Out=14. mfE=10 -> Out=2. busyE high for exactly 33 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234, same 33-cycle latency.
- mfE=10 during RUN -> stallE=1 every busy cycle; stallE=0 and Out=new HI the cycle after E33. DIVU presented while busy -> ignored, stallE=1.
- MTHI SrcAE=0xDEADBEEF, then mfE=10 next cycle -> Out=0xDEADBEEF. In the same cycle as the MTHI, Out shows the old HI.
- Start DIVU 100/7, assert reset at E10 -> HI=LO=0 and busyE=0 immediately. A following DIVU 9/3 completes normally with LO=3, HI=0.
